rs_hs_relay_fifo: RTL and testbench

RS_HS_RELAY_FIFO -- requirements
Module: rs_hs_relay_fifo

---
 rtl/rs_hs_relay_fifo.sv | 124 ++++++++++++
 tb/tb_rs_hs_relay_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rs_hs_relay_fifo.sv
// Relay FIFO: L forward/backward register stages feed a REAL_DEPTH tail buffer with first-word fall-through; latency L+1.
// Writer is throttled by if_full_n, which is the tail credit delayed L cycles; sticky checker under RS_HS_RELAY_PROTO_CHECK_EN.
module rs_hs_relay_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 24,
  parameter int PIPELINE_LEVEL = 2,
  localparam int GRACE      = 2 * PIPELINE_LEVEL,
  localparam int REAL_DEPTH = DEPTH + GRACE,
  localparam int CNT_WIDTH  = $clog2(REAL_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [CNT_WIDTH-1:0]  fill_level,
  output logic                  proto_err
);
  localparam int PTR_WIDTH = $clog2(REAL_DEPTH);

  logic                  wr_acc, arr_vld, pop, credit_raw;
  logic [DATA_WIDTH-1:0] arr_dat;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [REAL_DEPTH];

  assign wr_acc     = if_write & if_full_n;
  assign pop        = if_read & if_empty_n;
  assign credit_raw = (cnt_q < CNT_WIDTH'(DEPTH));

  generate
    if (PIPELINE_LEVEL == 0) begin : g_direct
      assign arr_vld   = wr_acc;
      assign arr_dat   = if_din;
      assign if_full_n = credit_raw;
    end else begin : g_relay
      logic [PIPELINE_LEVEL-1:0] fwd_vld_q, bwd_crd_q;
      logic [DATA_WIDTH-1:0]     fwd_dat_q [PIPELINE_LEVEL];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          fwd_vld_q <= '0;
          bwd_crd_q <= '1;
        end else begin
          fwd_vld_q[0] <= wr_acc;
          bwd_crd_q[0] <= credit_raw;
          for (int i = 1; i < PIPELINE_LEVEL; i++) begin
            fwd_vld_q[i] <= fwd_vld_q[i-1];
            bwd_crd_q[i] <= bwd_crd_q[i-1];
          end
        end
      end

      // payload stages carry no reset; the valid bits alone qualify them
      always_ff @(posedge clk) begin
        fwd_dat_q[0] <= if_din;
        for (int i = 1; i < PIPELINE_LEVEL; i++) begin
          fwd_dat_q[i] <= fwd_dat_q[i-1];
        end
      end

      assign arr_vld   = fwd_vld_q[PIPELINE_LEVEL-1];
      assign arr_dat   = fwd_dat_q[PIPELINE_LEVEL-1];
      assign if_full_n = bwd_crd_q[PIPELINE_LEVEL-1];
    end
  endgenerate

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(REAL_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  always_comb begin
    wr_ptr_d = arr_vld ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (arr_vld && !pop) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (!arr_vld && pop) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_vld) begin
      mem[wr_ptr_q] <= arr_dat;
    end
  end

  assign fill_level = cnt_q;
  assign if_empty_n = (cnt_q != '0);
  assign if_dout    = if_empty_n ? mem[rd_ptr_q] : '0;

`ifdef RS_HS_RELAY_PROTO_CHECK_EN
  logic proto_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else if ((if_write & ~if_full_n) | (if_read & ~if_empty_n)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rs_hs_relay_fifo.sv
// Directed bench for rs_hs_relay_fifo: one L=2/DEPTH=4 instance and one L=0/DEPTH=4 instance.
module tb_rs_hs_relay_fifo;
  localparam int DW = 32;

`ifdef RS_HS_RELAY_PROTO_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] a_din, a_dout;
  logic          a_write, a_full_n, a_empty_n, a_read, a_perr;
  logic [3:0]    a_fill;
  logic [DW-1:0] b_din, b_dout;
  logic          b_write, b_full_n, b_empty_n, b_read, b_perr;
  logic [2:0]    b_fill;

  rs_hs_relay_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .PIPELINE_LEVEL(2)) u_dut (
    .clk(clk), .reset(reset), .if_din(a_din), .if_write(a_write), .if_full_n(a_full_n),
    .if_dout(a_dout), .if_empty_n(a_empty_n), .if_read(a_read), .fill_level(a_fill),
    .proto_err(a_perr));

  rs_hs_relay_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .PIPELINE_LEVEL(0)) u_dut0 (
    .clk(clk), .reset(reset), .if_din(b_din), .if_write(b_write), .if_full_n(b_full_n),
    .if_dout(b_dout), .if_empty_n(b_empty_n), .if_read(b_read), .fill_level(b_fill),
    .proto_err(b_perr));

  int n_cmp = 0;
  int n_bad = 0;
  int accepted;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_din = '0; a_write = 1'b0; a_read = 1'b0;
    b_din = '0; b_write = 1'b0; b_read = 1'b0;

    // reset values, both during and right after reset
    repeat (3) @(negedge clk);
    check_eq("rst_full_n", 32'(a_full_n), 1);
    check_eq("rst_empty_n", 32'(a_empty_n), 0);
    check_eq("rst_perr", 32'(a_perr), 0);
    check_eq("rst_b_full_n", 32'(b_full_n), 1);
    reset = 1'b0;
    #1;
    check_eq("rel_full_n", 32'(a_full_n), 1);
    check_eq("rel_empty_n", 32'(a_empty_n), 0);
    check_eq("rel_dout", a_dout, 0);
    check_eq("rel_fill", 32'(a_fill), 0);
    check_eq("rel_perr", 32'(a_perr), 0);

    // back-pressure: write every cycle, no reads
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("bp_full_n_c0", 32'(a_full_n), 1);
      if (c == 7) check_eq("bp_full_n_c7", 32'(a_full_n), 1);
      if (c == 8) check_eq("bp_full_n_c8", 32'(a_full_n), 0);
      a_write = 1'b1;
      a_din   = 32'hC0DE_0000 + 32'(c);
      if (a_full_n) begin
        accepted++;
        exp_q.push_back(a_din);
      end
    end
    @(negedge clk);
    a_write = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("bp_accepted", 32'(accepted), 8);
    check_eq("bp_fill", 32'(a_fill), 8);
    check_eq("bp_full_n_held", 32'(a_full_n), 0);
    check_eq("bp_perr", 32'(a_perr), 32'(PERR_EXP));
    a_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_v = exp_q.pop_front();
      check_eq($sformatf("bp_rd%0d", k), a_dout, exp_v);
      @(negedge clk);
    end
    a_read = 1'b0;
    check_eq("bp_drained_empty_n", 32'(a_empty_n), 0);
    check_eq("bp_drained_dout", a_dout, 0);
    repeat (3) @(negedge clk);
    check_eq("bp_full_n_back", 32'(a_full_n), 1);

    // latency: write 0xA5 in cycle 0, visible in cycle 3, popped in cycle 3
    @(negedge clk); a_write = 1'b1; a_din = 32'hA5;
    @(negedge clk); a_write = 1'b0;
    check_eq("lat_c1_empty_n", 32'(a_empty_n), 0);
    @(negedge clk);
    check_eq("lat_c2_empty_n", 32'(a_empty_n), 0);
    @(negedge clk);
    check_eq("lat_c3_empty_n", 32'(a_empty_n), 1);
    check_eq("lat_c3_dout", a_dout, 32'hA5);
    check_eq("lat_c3_fill", 32'(a_fill), 1);
    a_read = 1'b1;
    @(negedge clk); a_read = 1'b0;
    check_eq("lat_c4_fill", 32'(a_fill), 0);
    check_eq("lat_c4_empty_n", 32'(a_empty_n), 0);

    // steady stream at fill 3: arrival and pop together, pointers wrap 7->0
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 5) check_eq("sim_fill_c5", 32'(a_fill), 3);
      if (c >= 6 && c <= 14) check_eq($sformatf("sim_fill_c%0d", c), 32'(a_fill), 3);
      a_write = (c < 12);
      a_din   = 32'h5000 + 32'(c);
      if (a_write && a_full_n) exp_q.push_back(a_din);
      a_read = (c >= 5 && c < 17);
      if (a_read && a_empty_n) begin
        exp_v = exp_q.pop_front();
        check_eq($sformatf("sim_rd_c%0d", c), a_dout, exp_v);
      end
    end
    a_write = 1'b0; a_read = 1'b0;
    check_eq("sim_all_popped", 32'(exp_q.size()), 0);
    check_eq("sim_fill_end", 32'(a_fill), 0);

    // L=0: continuous writes, credit is combinational
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 3) check_eq("l0_full_n_c3", 32'(b_full_n), 1);
      if (c == 4) check_eq("l0_full_n_c4", 32'(b_full_n), 0);
      b_write = 1'b1;
      b_din   = 32'hB00 + 32'(c);
      if (b_full_n) begin
        accepted++;
        exp_q.push_back(b_din);
      end
    end
    @(negedge clk); b_write = 1'b0;
    check_eq("l0_accepted", 32'(accepted), 4);
    check_eq("l0_fill", 32'(b_fill), 4);
    check_eq("l0_perr", 32'(b_perr), 32'(PERR_EXP));
    b_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      check_eq($sformatf("l0_rd%0d", k), b_dout, exp_v);
      @(negedge clk);
    end
    b_read = 1'b0;
    check_eq("l0_empty_n", 32'(b_empty_n), 0);

    // reset mid-operation, between clock edges, with data buffered and in flight
    @(negedge clk); a_write = 1'b1; a_din = 32'h11;
    @(negedge clk); a_din = 32'h22;
    @(negedge clk); a_write = 1'b0;
    @(negedge clk);
    check_eq("mid_pre_fill", 32'(a_fill), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_fill", 32'(a_fill), 0);
    check_eq("mid_empty_n", 32'(a_empty_n), 0);
    check_eq("mid_dout", a_dout, 0);
    check_eq("mid_full_n", 32'(a_full_n), 1);
    check_eq("mid_perr", 32'(a_perr), 0);
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_post_empty_n", 32'(a_empty_n), 0);
    check_eq("mid_post_fill", 32'(a_fill), 0);

    // read while empty: flagged only with the checker built, ignored either way
    @(negedge clk); a_read = 1'b1;
    @(negedge clk); a_read = 1'b0;
    check_eq("pe_perr_next", 32'(a_perr), 32'(PERR_EXP));
    check_eq("pe_fill", 32'(a_fill), 0);
    check_eq("pe_empty_n", 32'(a_empty_n), 0);
    a_write = 1'b1; a_din = 32'h77;
    @(negedge clk); a_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pe_perr_held", 32'(a_perr), 32'(PERR_EXP));
    check_eq("pe_after_dout", a_dout, 32'h77);
    check_eq("pe_after_fill", 32'(a_fill), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
